wb_commit: RTL and testbench

- Writeback/commit stage. Consumes the MEM/WB pipeline register outputs: the EX result, the load result, and the IF/ID exception flags.
- Drives the single register-file write port and retires instructions.
- Sequences machine-mode traps and mret into CSR writes, pipeline flush and PC redirect.
- Sits between the MEM/WB register and the regfile/CSR/fetch redirect logic.

---
 rtl/wb_commit_pkg.sv | 34 +++
 rtl/wb_trap_fsm.sv | 106 ++++++++++
 rtl/wb_commit.sv | 147 ++++++++++++++
 tb/tb_wb_commit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_pkg.sv
// Shared definitions for the writeback/commit stage: trap cause codes,
// trap FSM state encodings and the cause priority encoder.
package wb_commit_pkg;

    localparam int CAUSE_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SAVE     = 2'd1,
        REDIRECT = 2'd2,
        MRET     = 2'd3
    } wb_state_e;

    localparam logic [CAUSE_WIDTH-1:0] CAUSE_MISALIGN = 4'd0;
    localparam logic [CAUSE_WIDTH-1:0] CAUSE_BUS_ERR  = 4'd1;
    localparam logic [CAUSE_WIDTH-1:0] CAUSE_ILEGL    = 4'd2;
    localparam logic [CAUSE_WIDTH-1:0] CAUSE_EBREAK   = 4'd3;
    localparam logic [CAUSE_WIDTH-1:0] CAUSE_ECALL    = 4'd11;

    // Fetch-side faults outrank decode-side ones; ecall is the fallback.
    function automatic logic [CAUSE_WIDTH-1:0] encode_cause(
        input logic misalign,
        input logic bus_err,
        input logic ilegl,
        input logic ebreak
    );
        if (misalign)     return CAUSE_MISALIGN;
        else if (bus_err) return CAUSE_BUS_ERR;
        else if (ilegl)   return CAUSE_ILEGL;
        else if (ebreak)  return CAUSE_EBREAK;
        else              return CAUSE_ECALL;
    endfunction

endpackage

// File: rtl/wb_trap_fsm.sv
// Trap/mret sequencer: latches PC and cause on an exception, then drives
// the mepc/mcause writes, flush and fetch redirect. o_state is the live state.
module wb_trap_fsm
    import wb_commit_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter int XLEN     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_no_pend,
    input  logic                i_misalign,
    input  logic                i_bus_err,
    input  logic                i_ilegl,
    input  logic                i_ecall,
    input  logic                i_ebreak,
    input  logic                i_mret,
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic [XLEN-1:0]     i_mtvec,
    input  logic [XLEN-1:0]     i_mepc,
    output logic                o_excp,
    output logic [1:0]          o_state,
    output logic                o_mepc_wen,
    output logic [XLEN-1:0]     o_mepc_wdata,
    output logic                o_mcause_wen,
    output logic [XLEN-1:0]     o_mcause_wdata,
    output logic                o_flush,
    output logic                o_redirect_en,
    output logic [PC_WIDTH-1:0] o_redirect_pc,
    output logic                o_retire
);

    wb_state_e              r_state;
    wb_state_e              w_next;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [CAUSE_WIDTH-1:0] r_cause;
    logic                   w_take;

    assign o_excp  = i_misalign | i_bus_err | i_ilegl | i_ecall | i_ebreak;
    assign w_take  = (r_state == IDLE) && i_no_pend;
    assign o_state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_cause <= '0;
        end else begin
            r_state <= w_next;
            if (w_take && o_excp) begin
                r_pc    <= i_pc;
                r_cause <= encode_cause(i_misalign, i_bus_err, i_ilegl, i_ebreak);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_take && o_excp)        w_next = SAVE;
                else if (w_take && i_mret)   w_next = MRET;
            end
            SAVE:     w_next = REDIRECT;
            REDIRECT: w_next = IDLE;
            MRET:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        o_mepc_wen     = 1'b0;
        o_mepc_wdata   = '0;
        o_mcause_wen   = 1'b0;
        o_mcause_wdata = '0;
        o_flush        = 1'b0;
        o_redirect_en  = 1'b0;
        o_redirect_pc  = '0;
        o_retire       = 1'b0;
        if (!rst) begin
            case (r_state)
                SAVE: begin
                    o_mepc_wen     = 1'b1;
                    o_mepc_wdata   = XLEN'(r_pc);
                    o_mcause_wen   = 1'b1;
                    o_mcause_wdata = XLEN'(r_cause);
                    o_flush        = 1'b1;
                    // ecall/ebreak complete by trapping, so they retire here.
                    o_retire       = (r_cause == CAUSE_ECALL) || (r_cause == CAUSE_EBREAK);
                end
                REDIRECT: begin
                    o_redirect_en = 1'b1;
                    o_redirect_pc = PC_WIDTH'(i_mtvec & ~XLEN'(3));
                    o_flush       = 1'b1;
                end
                MRET: begin
                    o_redirect_en = 1'b1;
                    o_redirect_pc = PC_WIDTH'(i_mepc);
                    o_flush       = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: arbitrates the single regfile write port with a
// 1-entry pending buffer and retires instructions. Optional instret counter
// is enabled by defining WB_RETIRE_CNT_EN.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int PC_WIDTH      = 32,
    parameter int XLEN          = 32,
    parameter int REG_IDX_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PC_WIDTH-1:0]      wb_pc_i,
    input  logic [REG_IDX_WIDTH-1:0] wb_ex_rd_idx_i,
    input  logic                     wb_ex_rd_en_i,
    input  logic [XLEN-1:0]          wb_ex_rd_wdata_i,
    input  logic [REG_IDX_WIDTH-1:0] wb_mem_rd_idx_i,
    input  logic                     wb_mem_rd_en_i,
    input  logic [XLEN-1:0]          wb_mem_rd_wdata_i,
    input  logic                     wb_if_excp_misalign_i,
    input  logic                     wb_if_excp_bus_err_i,
    input  logic                     wb_id_excp_ilegl_instr_i,
    input  logic                     wb_id_excp_ecall_i,
    input  logic                     wb_id_excp_ebreak_i,
    input  logic                     wb_id_excp_mret_i,
    input  logic [XLEN-1:0]          csr_mtvec_i,
    input  logic [XLEN-1:0]          csr_mepc_i,
    output logic                     rf_wen_o,
    output logic [REG_IDX_WIDTH-1:0] rf_widx_o,
    output logic [XLEN-1:0]          rf_wdata_o,
    output logic                     csr_mepc_wen_o,
    output logic [XLEN-1:0]          csr_mepc_wdata_o,
    output logic                     csr_mcause_wen_o,
    output logic [XLEN-1:0]          csr_mcause_wdata_o,
    output logic                     wb_stall_o,
    output logic                     flush_o,
    output logic                     redirect_en_o,
    output logic [PC_WIDTH-1:0]      redirect_pc_o,
    output logic                     retire_o,
    output logic [63:0]              minstret_o
);

    logic                     r_pend_vld;
    logic [REG_IDX_WIDTH-1:0] r_pend_idx;
    logic [XLEN-1:0]          r_pend_data;
    logic                     w_ex_en;
    logic                     w_mem_en;
    logic                     w_excp;
    logic [1:0]               w_state;
    logic                     w_capture;
    logic                     w_trap_retire;

    assign w_ex_en  = wb_ex_rd_en_i  && (wb_ex_rd_idx_i  != '0);
    assign w_mem_en = wb_mem_rd_en_i && (wb_mem_rd_idx_i != '0);

    wb_trap_fsm #(.PC_WIDTH(PC_WIDTH), .XLEN(XLEN)) u_trap_fsm (
        .clk            (clk),
        .rst            (rst),
        .i_no_pend      (!r_pend_vld),
        .i_misalign     (wb_if_excp_misalign_i),
        .i_bus_err      (wb_if_excp_bus_err_i),
        .i_ilegl        (wb_id_excp_ilegl_instr_i),
        .i_ecall        (wb_id_excp_ecall_i),
        .i_ebreak       (wb_id_excp_ebreak_i),
        .i_mret         (wb_id_excp_mret_i),
        .i_pc           (wb_pc_i),
        .i_mtvec        (csr_mtvec_i),
        .i_mepc         (csr_mepc_i),
        .o_excp         (w_excp),
        .o_state        (w_state),
        .o_mepc_wen     (csr_mepc_wen_o),
        .o_mepc_wdata   (csr_mepc_wdata_o),
        .o_mcause_wen   (csr_mcause_wen_o),
        .o_mcause_wdata (csr_mcause_wdata_o),
        .o_flush        (flush_o),
        .o_redirect_en  (redirect_en_o),
        .o_redirect_pc  (redirect_pc_o),
        .o_retire       (w_trap_retire)
    );

    assign wb_stall_o = r_pend_vld && !rst;

    always_comb begin
        rf_wen_o   = 1'b0;
        rf_widx_o  = '0;
        rf_wdata_o = '0;
        retire_o   = 1'b0;
        w_capture  = 1'b0;
        if (!rst) begin
            if (r_pend_vld) begin
                rf_wen_o   = 1'b1;
                rf_widx_o  = r_pend_idx;
                rf_wdata_o = r_pend_data;
                retire_o   = 1'b1;
            end else if ((w_state == IDLE) && !w_excp) begin
                if (w_ex_en && w_mem_en && (wb_ex_rd_idx_i != wb_mem_rd_idx_i)) begin
                    // Two targets: EX now, load next cycle; retire on the second.
                    rf_wen_o   = 1'b1;
                    rf_widx_o  = wb_ex_rd_idx_i;
                    rf_wdata_o = wb_ex_rd_wdata_i;
                    w_capture  = 1'b1;
                end else if (w_mem_en) begin
                    rf_wen_o   = 1'b1;
                    rf_widx_o  = wb_mem_rd_idx_i;
                    rf_wdata_o = wb_mem_rd_wdata_i;
                    retire_o   = 1'b1;
                end else if (w_ex_en) begin
                    rf_wen_o   = 1'b1;
                    rf_widx_o  = wb_ex_rd_idx_i;
                    rf_wdata_o = wb_ex_rd_wdata_i;
                    retire_o   = 1'b1;
                end else begin
                    retire_o   = 1'b1;
                end
            end
            if (w_trap_retire) retire_o = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_vld  <= 1'b0;
            r_pend_idx  <= '0;
            r_pend_data <= '0;
        end else if (r_pend_vld) begin
            r_pend_vld  <= 1'b0;
        end else if (w_capture) begin
            r_pend_vld  <= 1'b1;
            r_pend_idx  <= wb_mem_rd_idx_i;
            r_pend_data <= wb_mem_rd_wdata_i;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] r_minstret;

    always_ff @(posedge clk) begin
        if (rst)           r_minstret <= '0;
        else if (retire_o) r_minstret <= r_minstret + 64'd1;
    end

    assign minstret_o = r_minstret;
`else
    assign minstret_o = 64'd0;
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: directed cases then random instructions
// checked cycle by cycle against an instruction-level reference model.
module tb_wb_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_pc_i;
    logic [4:0]  wb_ex_rd_idx_i, wb_mem_rd_idx_i;
    logic        wb_ex_rd_en_i, wb_mem_rd_en_i;
    logic [31:0] wb_ex_rd_wdata_i, wb_mem_rd_wdata_i;
    logic        wb_if_excp_misalign_i, wb_if_excp_bus_err_i, wb_id_excp_ilegl_instr_i;
    logic        wb_id_excp_ecall_i, wb_id_excp_ebreak_i, wb_id_excp_mret_i;
    logic [31:0] csr_mtvec_i, csr_mepc_i;
    logic        rf_wen_o;
    logic [4:0]  rf_widx_o;
    logic [31:0] rf_wdata_o;
    logic        csr_mepc_wen_o, csr_mcause_wen_o;
    logic [31:0] csr_mepc_wdata_o, csr_mcause_wdata_o;
    logic        wb_stall_o, flush_o, redirect_en_o, retire_o;
    logic [31:0] redirect_pc_o;
    logic [63:0] minstret_o;

    wb_commit dut (
        .clk(clk), .rst(rst), .wb_pc_i(wb_pc_i),
        .wb_ex_rd_idx_i(wb_ex_rd_idx_i), .wb_ex_rd_en_i(wb_ex_rd_en_i), .wb_ex_rd_wdata_i(wb_ex_rd_wdata_i),
        .wb_mem_rd_idx_i(wb_mem_rd_idx_i), .wb_mem_rd_en_i(wb_mem_rd_en_i), .wb_mem_rd_wdata_i(wb_mem_rd_wdata_i),
        .wb_if_excp_misalign_i(wb_if_excp_misalign_i), .wb_if_excp_bus_err_i(wb_if_excp_bus_err_i),
        .wb_id_excp_ilegl_instr_i(wb_id_excp_ilegl_instr_i), .wb_id_excp_ecall_i(wb_id_excp_ecall_i),
        .wb_id_excp_ebreak_i(wb_id_excp_ebreak_i), .wb_id_excp_mret_i(wb_id_excp_mret_i),
        .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
        .rf_wen_o(rf_wen_o), .rf_widx_o(rf_widx_o), .rf_wdata_o(rf_wdata_o),
        .csr_mepc_wen_o(csr_mepc_wen_o), .csr_mepc_wdata_o(csr_mepc_wdata_o),
        .csr_mcause_wen_o(csr_mcause_wen_o), .csr_mcause_wdata_o(csr_mcause_wdata_o),
        .wb_stall_o(wb_stall_o), .flush_o(flush_o), .redirect_en_o(redirect_en_o),
        .redirect_pc_o(redirect_pc_o), .retire_o(retire_o), .minstret_o(minstret_o)
    );

    always #5 clk = ~clk;

    // One instruction as presented by the MEM/WB register.
    typedef struct {
        logic [31:0] pc;
        logic        ex_en;  logic [4:0] ex_idx;  logic [31:0] ex_data;
        logic        mem_en; logic [4:0] mem_idx; logic [31:0] mem_data;
        logic        misalign, bus_err, ilegl, ecall, ebreak, mret;
        logic [31:0] mtvec, mepc;
    } ins_t;

    // Expected outputs for one cycle.
    typedef struct {
        logic        rf_wen; logic [4:0] idx; logic [31:0] data;
        logic        mepc_wen; logic [31:0] mepc;
        logic        mcause_wen; logic [31:0] mcause;
        logic        stall, flush, redir_en; logic [31:0] redir_pc;
        logic        retire;
    } cyc_t;

    cyc_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    longint      model_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expands one instruction into its cycle-by-cycle effect.
    function automatic void model(input ins_t t);
        cyc_t c;
        bit   exw, memw, excp;
        int   cause;
        c    = '{default: '0};
        exw  = t.ex_en && (t.ex_idx != 0);
        memw = t.mem_en && (t.mem_idx != 0);
        excp = t.misalign || t.bus_err || t.ilegl || t.ecall || t.ebreak;
        if (excp) begin
            if (t.misalign)     cause = 0;
            else if (t.bus_err) cause = 1;
            else if (t.ilegl)   cause = 2;
            else if (t.ebreak)  cause = 3;
            else                cause = 11;
            exp_q.push_back(c);
            c = '{default: '0};
            c.mepc_wen = 1; c.mepc = t.pc; c.mcause_wen = 1; c.mcause = cause;
            c.flush = 1; c.retire = (cause == 3 || cause == 11);
            exp_q.push_back(c);
            c = '{default: '0};
            c.redir_en = 1; c.redir_pc = {t.mtvec[31:2], 2'b00}; c.flush = 1;
            exp_q.push_back(c);
        end else if (exw && memw && t.ex_idx != t.mem_idx) begin
            c.rf_wen = 1; c.idx = t.ex_idx; c.data = t.ex_data;
            exp_q.push_back(c);
            c = '{default: '0};
            c.rf_wen = 1; c.idx = t.mem_idx; c.data = t.mem_data; c.stall = 1; c.retire = 1;
            exp_q.push_back(c);
        end else begin
            if (memw) begin c.rf_wen = 1; c.idx = t.mem_idx; c.data = t.mem_data; end
            else if (exw) begin c.rf_wen = 1; c.idx = t.ex_idx; c.data = t.ex_data; end
            c.retire = 1;
            exp_q.push_back(c);
            if (t.mret) begin
                c = '{default: '0};
                c.redir_en = 1; c.redir_pc = t.mepc; c.flush = 1;
                exp_q.push_back(c);
            end
        end
    endfunction

    task automatic drive_ins(input ins_t t);
        wb_pc_i = t.pc;
        wb_ex_rd_en_i = t.ex_en;   wb_ex_rd_idx_i = t.ex_idx;   wb_ex_rd_wdata_i = t.ex_data;
        wb_mem_rd_en_i = t.mem_en; wb_mem_rd_idx_i = t.mem_idx; wb_mem_rd_wdata_i = t.mem_data;
        wb_if_excp_misalign_i = t.misalign; wb_if_excp_bus_err_i = t.bus_err;
        wb_id_excp_ilegl_instr_i = t.ilegl; wb_id_excp_ecall_i = t.ecall;
        wb_id_excp_ebreak_i = t.ebreak;     wb_id_excp_mret_i = t.mret;
        csr_mtvec_i = t.mtvec; csr_mepc_i = t.mepc;
    endtask

    // Garbage on the MEM/WB side while the DUT must ignore its inputs.
    task automatic drive_junk();
        wb_pc_i = $urandom;
        wb_ex_rd_en_i = 1'($urandom);  wb_ex_rd_idx_i = 5'($urandom);  wb_ex_rd_wdata_i = $urandom;
        wb_mem_rd_en_i = 1'($urandom); wb_mem_rd_idx_i = 5'($urandom); wb_mem_rd_wdata_i = $urandom;
        wb_if_excp_misalign_i = 1'($urandom); wb_if_excp_bus_err_i = 1'($urandom);
        wb_id_excp_ilegl_instr_i = 1'($urandom); wb_id_excp_ecall_i = 1'($urandom);
        wb_id_excp_ebreak_i = 1'($urandom); wb_id_excp_mret_i = 1'($urandom);
    endtask

    task automatic drive_bubble();
        ins_t t;
        t = '{default: '0};
        drive_ins(t);
    endtask

    function automatic logic [63:0] exp_minstret();
`ifdef WB_RETIRE_CNT_EN
        return 64'(model_cnt);
`else
        return 64'd0;
`endif
    endfunction

    // Called just after a posedge; returns just after the instruction's last posedge.
    task automatic run(input ins_t t);
        cyc_t e;
        bit   first;
        model(t);
        first = 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (first) drive_ins(t); else drive_junk();
            first = 0;
            @(negedge clk);
            chk("rf_wen", 64'(rf_wen_o), 64'(e.rf_wen));
            if (e.rf_wen) begin
                chk("rf_widx", 64'(rf_widx_o), 64'(e.idx));
                chk("rf_wdata", 64'(rf_wdata_o), 64'(e.data));
            end
            chk("mepc_wen", 64'(csr_mepc_wen_o), 64'(e.mepc_wen));
            if (e.mepc_wen) chk("mepc_wdata", 64'(csr_mepc_wdata_o), 64'(e.mepc));
            chk("mcause_wen", 64'(csr_mcause_wen_o), 64'(e.mcause_wen));
            if (e.mcause_wen) chk("mcause_wdata", 64'(csr_mcause_wdata_o), 64'(e.mcause));
            chk("stall", 64'(wb_stall_o), 64'(e.stall));
            chk("flush", 64'(flush_o), 64'(e.flush));
            chk("redirect_en", 64'(redirect_en_o), 64'(e.redir_en));
            if (e.redir_en) chk("redirect_pc", 64'(redirect_pc_o), 64'(e.redir_pc));
            chk("retire", 64'(retire_o), 64'(e.retire));
            chk("minstret", minstret_o, exp_minstret());
            if (e.retire) model_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rf_wen"}, 64'(rf_wen_o), 64'd0);
        chk({tag, "_rf_widx"}, 64'(rf_widx_o), 64'd0);
        chk({tag, "_rf_wdata"}, 64'(rf_wdata_o), 64'd0);
        chk({tag, "_mepc_wen"}, 64'(csr_mepc_wen_o), 64'd0);
        chk({tag, "_mepc_wdata"}, 64'(csr_mepc_wdata_o), 64'd0);
        chk({tag, "_mcause_wen"}, 64'(csr_mcause_wen_o), 64'd0);
        chk({tag, "_mcause_wdata"}, 64'(csr_mcause_wdata_o), 64'd0);
        chk({tag, "_stall"}, 64'(wb_stall_o), 64'd0);
        chk({tag, "_flush"}, 64'(flush_o), 64'd0);
        chk({tag, "_redirect_en"}, 64'(redirect_en_o), 64'd0);
        chk({tag, "_redirect_pc"}, 64'(redirect_pc_o), 64'd0);
        chk({tag, "_retire"}, 64'(retire_o), 64'd0);
        chk({tag, "_minstret"}, minstret_o, 64'd0);
    endtask

    function automatic ins_t rand_ins();
        ins_t t;
        int   kind;
        t = '{default: '0};
        t.pc = $urandom; t.mtvec = $urandom; t.mepc = $urandom;
        t.ex_en = 1'($urandom);  t.ex_idx = 5'($urandom_range(0, 31));  t.ex_data = $urandom;
        t.mem_en = 1'($urandom); t.mem_idx = 5'($urandom_range(0, 31)); t.mem_data = $urandom;
        if ($urandom_range(0, 3) == 0) t.mem_idx = t.ex_idx;
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
            t.misalign = 1'($urandom); t.bus_err = 1'($urandom); t.ilegl = 1'($urandom);
            t.ecall = 1'($urandom); t.ebreak = 1'($urandom); t.mret = 1'($urandom);
            if (!(t.misalign || t.bus_err || t.ilegl || t.ecall || t.ebreak)) t.ecall = 1;
        end else if (kind == 1) begin
            case ($urandom_range(0, 4))
                0: t.misalign = 1;
                1: t.bus_err = 1;
                2: t.ilegl = 1;
                3: t.ebreak = 1;
                default: t.ecall = 1;
            endcase
        end else if (kind == 2) begin
            t.mret = 1; t.ex_en = 0; t.mem_en = 0;
        end
        return t;
    endfunction

    initial begin
        ins_t t;

        // Reset state
        rst = 1'b1;
        drive_bubble();
        csr_mtvec_i = 32'h0; csr_mepc_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        model_cnt = 0;

        // Single EX write
        t = '{default: '0};
        t.ex_en = 1; t.ex_idx = 5; t.ex_data = 32'hA5;
        run(t);

        // EX and load to different registers: pending write with stall
        t = '{default: '0};
        t.ex_en = 1; t.ex_idx = 3; t.ex_data = 32'h11;
        t.mem_en = 1; t.mem_idx = 4; t.mem_data = 32'h22;
        run(t);
        t = '{default: '0};
        run(t);

        // Same destination: younger (load) value only
        t = '{default: '0};
        t.ex_en = 1; t.ex_idx = 7; t.ex_data = 32'h1;
        t.mem_en = 1; t.mem_idx = 7; t.mem_data = 32'h2;
        run(t);

        // x0 requests behave as disabled
        t = '{default: '0};
        t.ex_en = 1; t.ex_idx = 0; t.ex_data = 32'hDEAD;
        t.mem_en = 1; t.mem_idx = 9; t.mem_data = 32'h99;
        run(t);

        // ecall trap sequence
        t = '{default: '0};
        t.pc = 32'h100; t.mtvec = 32'h205; t.mepc = 32'h5555_0000; t.ecall = 1;
        t.ex_en = 1; t.ex_idx = 6; t.ex_data = 32'h66;
        run(t);

        // Exception beats mret; misalign has top priority
        t = '{default: '0};
        t.pc = 32'h240; t.mtvec = 32'h8000_0003; t.mepc = 32'h1234_5678;
        t.misalign = 1; t.ebreak = 1; t.mret = 1;
        run(t);

        // Plain mret
        t = '{default: '0};
        t.mepc = 32'hCAFE_0040; t.mret = 1;
        run(t);

        // Randomized instruction stream
        for (int i = 0; i < 300; i++) begin
            t = rand_ins();
            run(t);
        end

        // Reset during SAVE aborts the trap
        t = '{default: '0};
        t.pc = 32'h300; t.mtvec = 32'h400; t.ebreak = 1;
        drive_ins(t);
        @(posedge clk); #1;
        rst = 1'b1;
        drive_bubble();
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk_all_zero("mid_trap_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        model_cnt = 0;
        t = '{default: '0};
        t.ex_en = 1; t.ex_idx = 12; t.ex_data = 32'h1200;
        run(t);
        t = '{default: '0};
        run(t);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
